// File: rtl/osu_clkdiv_ctrl.sv
`default_nettype none
//============================================================================
// Module   : osu_clkdiv_ctrl
// Purpose  : Programmable glitch-free clock divider/gate. It produces the
//            root divided clock for the local clock-tree buffer. The output
//            is a registered clock with 50% duty cycle and a period of
//            2*(D+1) CLK cycles. Start and stop are clean, so the output has
//            no runt high or low phases.
//            A divisor change is requested with DIV/DIV_LOAD. The new value
//            is applied only at the start of a high phase, or while idle,
//            and DIV_ACK then pulses for one cycle.
// Ports    : CLK      - source clock, rising edge
//            RST      - synchronous active-high reset
//            EN       - run request (level)
//            DIV      - new divisor, sampled when DIV_LOAD=1
//            DIV_LOAD - one-cycle load request
//            DIV_ACK  - one-cycle pulse when a loaded divisor becomes active
//            CLKOUT   - registered divided clock
//            RUNNING  - high in RUN and DRAIN
//            PERIODS  - (CLKDIV_PERIOD_CNT_EN only) saturating count of
//                       CLKOUT rising transitions since start
// Macro    : CLKDIV_PERIOD_CNT_EN enables the PERIODS output and its counter.
// Revision : 1.0 - initial release
//============================================================================
module osu_clkdiv_ctrl #(
    parameter int WIDTH     = 8,
    parameter int RESET_DIV = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic [WIDTH-1:0] DIV,
    input  logic             DIV_LOAD,
    output logic             DIV_ACK,
    output logic             CLKOUT,
    output logic             RUNNING
`ifdef CLKDIV_PERIOD_CNT_EN
    ,
    output logic [15:0]      PERIODS
`endif
);

    localparam logic [WIDTH-1:0] c_reset_div = RESET_DIV[WIDTH-1:0];

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_d_act;
    logic [WIDTH-1:0] r_d_pend;
    logic             r_pend;
    logic             r_clkout;
    logic             r_ack;

    logic w_active;
    logic w_wrap;
    logic w_rise;
    logic w_apply;
    logic w_stop;

    assign w_active = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign w_wrap   = w_active && (r_cnt == r_d_act);
    // End of a full low phase: a new high phase would begin here.
    assign w_rise   = w_wrap && !r_clkout;
    // Divisor may only change where no phase is partially elapsed.
    assign w_apply  = (r_state == S_IDLE) || w_rise;
    // A stop only completes after a full low phase, so the last low phase
    // is never truncated.
    assign w_stop   = (r_state == S_DRAIN) && !EN && w_rise;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_d_act  <= c_reset_div;
            r_d_pend <= '0;
            r_pend   <= 1'b0;
            r_clkout <= 1'b0;
            r_ack    <= 1'b0;
        end else begin
            // Divisor handshake. A load that coincides with an apply point
            // bypasses the pending register.
            r_ack <= 1'b0;
            if (w_apply) begin
                if (DIV_LOAD) begin
                    r_d_act <= DIV;
                    r_pend  <= 1'b0;
                    r_ack   <= 1'b1;
                end else if (r_pend) begin
                    r_d_act <= r_d_pend;
                    r_pend  <= 1'b0;
                    r_ack   <= 1'b1;
                end
            end else if (DIV_LOAD) begin
                r_d_pend <= DIV;
                r_pend   <= 1'b1;
            end

            // Phase generation
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (EN) begin
                        r_state  <= S_RUN;
                        r_clkout <= 1'b1;
                    end else begin
                        r_clkout <= 1'b0;
                    end
                end
                default: begin
                    // RUN and DRAIN share the waveform; only EN selects
                    // which one follows, so re-enabling in DRAIN is seamless.
                    r_state <= EN ? S_RUN : S_DRAIN;
                    if (w_stop) begin
                        r_state  <= S_IDLE;
                        r_clkout <= 1'b0;
                        r_cnt    <= '0;
                    end else if (w_wrap) begin
                        r_clkout <= ~r_clkout;
                        r_cnt    <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

`ifdef CLKDIV_PERIOD_CNT_EN
    logic [15:0] r_periods;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_periods <= '0;
        end else if ((r_state == S_IDLE) && EN) begin
            r_periods <= '0;
        end else if (w_rise && !w_stop && (r_periods != 16'hFFFF)) begin
            r_periods <= r_periods + 16'd1;
        end
    end

    assign PERIODS = r_periods;
`endif

    assign CLKOUT  = r_clkout;
    assign DIV_ACK = r_ack;
    assign RUNNING = w_active;

endmodule
`default_nettype wire
